wb_queue: RTL and testbench
===========================

# wb_queue

Parametrised write-back stage placed between the ME-side result producers and the register file. Accepts register write requests from NCH independent channels (e.g. ALU path, load path, long-latency unit), round-robin arbitrates one per cycle into a DEPTH-entry in-order write buffer, and drains the buffer to a single register-file write port under a valid/ready handshake. Provides a combinational bypass lookup over buffered entries so ID/EX forwarding can see results not yet committed.

## Interface
- NCH, 2, number of request channels (1..8)
- DEPTH, 4, write buffer entries (power of two, ≥2)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_valid_i  in  NCH  per-channel write request
- ch_waddr_i  in  NCH*AW  per-channel destination, channel i at [i*AW +: AW]
- ch_data_i  in  NCH*XLEN  per-channel data, channel i at [i*XLEN +: XLEN]
- ch_ready_o  out  NCH  per-channel accept; handshake when valid & ready
- rd_we_o  out  1  write request to register file (buffer non-empty)
- rd_waddr_o  out  AW  head entry address
- rd_data_o  out  XLEN  head entry data
- rf_ready_i  in  1  register file accepts head this cycle
- byp_raddr_i  in  AW  bypass lookup address
- byp_hit_o  out  1  buffered entry matches byp_raddr_i
- byp_data_o  out  XLEN  data of youngest matching entry
- count_o  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Arbitration: round-robin over ch_valid_i; grant = first valid channel strictly after last_grant, wrapping. last_grant resets to NCH-1 (channel 0 first). last_grant updates only on a completed handshake.
- At most one channel gets ch_ready_o high per cycle; non-granted channels see ready low and must hold request stable.
- pop = rd_we_o & rf_ready_i. Granted channel ready = (waddr==0) | !full | pop.
- Writes to x0: handshake completes, nothing enqueued, count unchanged, last_grant advances.
- Push on handshake with waddr≠0: entry written at tail, tail+1 (wraps mod DEPTH).
- Pop: head+1 (wraps), entry discarded.
- Push and pop same edge: count unchanged; permitted when full (pop frees slot).
- rd_we_o = (count≠0). rd_waddr_o/rd_data_o = head entry when non-empty, 0 when empty.
- Bypass: byp_hit_o = 1 if any valid buffered entry has waddr == byp_raddr_i and byp_raddr_i≠0; byp_data_o = youngest such entry (closest to tail), 0 on miss. Incoming (not yet pushed) requests not included.
- Order preserved: entries commit in push order, so later writes to same register win.
- Reset (async, rst_n low): count, head, tail = 0; storage cleared; last_grant = NCH-1; rd_we_o=0, rd_waddr_o=0, rd_data_o=0, byp_hit_o=0, byp_data_o=0, ch_ready_o reflects empty buffer combinationally. Reset mid-operation discards all buffered entries.

## Timing
- Push at edge k → rd_we_o high from edge k onward (1-cycle latency, no input-to-output combinational path on rd_* ).
- Combinational paths: rf_ready_i → ch_ready_o; ch_valid_i/ch_waddr_i → ch_ready_o; byp_raddr_i → byp_*.
- Throughput: one push and one pop per cycle sustained.
- rf_ready_i low holds head and rd_* stable.
- count_o registered, updated at edge.

## Test plan
- Reset then ch0 writes x5=0xDEADBEEF, rf_ready_i=1 → rd_we_o=1, rd_waddr_o=5, rd_data_o=0xDEADBEEF cycle after; count returns 0 after next edge.
- NCH=2, both channels valid continuously, rf_ready_i=1 → grants alternate ch0,ch1,ch0,…; rd_* order matches grant order.
- rf_ready_i=0, push 4 entries → count_o=4, ch_ready_o=0; then rf_ready_i=1 with ch0 valid → simultaneous push/pop, count stays 4.
- Buffer x3=1 then x3=2, byp_raddr_i=3 → byp_hit_o=1, byp_data_o=2; byp_raddr_i=0 → hit 0.
- ch1 writes x0 while full → ch_ready_o[1]=1, count unchanged, no rd_we_o for it.
- Assert rst_n low with 3 entries buffered → rd_we_o=0, count_o=0 immediately; after release next grant goes to ch0.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: write-back stage between the result producers and the register file.
// NCH request channels are round-robin arbitrated one per cycle into a DEPTH-entry
// in-order write buffer. The buffer drains to one register-file write port.
// A combinational bypass lookup exposes buffered results to forwarding logic.
//
// Handshake: a channel transfer happens on a cycle where ch_valid_i[i] & ch_ready_o[i]
// are both high. Only the granted channel can see ready high. A requester holds its
// address and data stable until that transfer. On the drain side the head entry
// leaves when rd_we_o & rf_ready_i are both high.
module wb_queue #(
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NCH-1:0]               ch_valid_i,
    input  logic [NCH*AW-1:0]            ch_waddr_i,
    input  logic [NCH*XLEN-1:0]          ch_data_i,
    output logic [NCH-1:0]               ch_ready_o,
    output logic                         rd_we_o,
    output logic [AW-1:0]                rd_waddr_o,
    output logic [XLEN-1:0]              rd_data_o,
    input  logic                         rf_ready_i,
    input  logic [AW-1:0]                byp_raddr_i,
    output logic                         byp_hit_o,
    output logic [XLEN-1:0]              byp_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    // Buffer storage and pointers
    logic [AW-1:0]   addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;

    // Unpacked per-channel views of the flat request buses
    logic [AW-1:0]   ch_waddr_a [NCH];
    logic [XLEN-1:0] ch_data_a  [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign ch_waddr_a[g] = ch_waddr_i[g*AW +: AW];
        assign ch_data_a[g]  = ch_data_i[g*XLEN +: XLEN];
    end

    // Arbitration and handshake signals
    logic            grant_valid;
    logic [GW-1:0]   grant_idx;
    logic [AW-1:0]   grant_addr;
    logic [XLEN-1:0] grant_data;
    logic            grant_ready;
    logic            empty, full, pop, push;
    int              cand;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = !empty && rf_ready_i;

    // Round-robin pick: first valid channel strictly after last_grant, wrapping
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NCH; i++) begin
            cand = int'(last_grant_q) + i;
            if (cand >= NCH) cand = cand - NCH;
            if (!grant_valid && ch_valid_i[GW'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(cand);
            end
        end
    end

    assign grant_addr = ch_waddr_a[grant_idx];
    assign grant_data = ch_data_a[grant_idx];

    // x0 writes are always accepted because they never occupy a slot.
    // A pop on the same edge frees a slot, so a full buffer can still accept.
    assign grant_ready = grant_valid && ((grant_addr == '0) || !full || pop);
    assign push        = grant_ready && (grant_addr != '0);
    assign ch_ready_o  = grant_ready ? (NCH'(1) << grant_idx) : '0;

    // Next-state computation for pointers, occupancy and arbitration history
    always_comb begin
        head_d       = pop  ? head_q + PW'(1) : head_q;
        tail_d       = push ? tail_q + PW'(1) : tail_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
        last_grant_d = grant_ready ? grant_idx : last_grant_q;
    end

    // State registers; reset drops every buffered entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            last_grant_q <= GW'(NCH - 1);
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            if (push) begin
                addr_q[tail_q] <= grant_addr;
                data_q[tail_q] <= grant_data;
            end
        end
    end

    // Drain port is driven purely from registered state
    assign rd_we_o    = !empty;
    assign rd_waddr_o = empty ? '0 : addr_q[head_q];
    assign rd_data_o  = empty ? '0 : data_q[head_q];
    assign count_o    = count_q;

    logic [PW-1:0] slot;

    // Bypass scan from oldest to youngest so the youngest match wins
    always_comb begin
        byp_hit_o  = 1'b0;
        byp_data_o = '0;
        slot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[slot] == byp_raddr_i) && (byp_raddr_i != '0)) begin
                byp_hit_o  = 1'b1;
                byp_data_o = data_q[slot];
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with NCH=2, DEPTH=4, XLEN=32, AW=5.
module tb_wb_queue;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ch_valid;
    logic [9:0]  ch_waddr;
    logic [63:0] ch_data;
    logic [1:0]  ch_ready;
    logic        rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_data;
    logic        rf_ready;
    logic [4:0]  byp_raddr;
    logic        byp_hit;
    logic [31:0] byp_data;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    wb_queue #(.NCH(2), .DEPTH(4), .XLEN(32), .AW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_valid_i  (ch_valid),
        .ch_waddr_i  (ch_waddr),
        .ch_data_i   (ch_data),
        .ch_ready_o  (ch_ready),
        .rd_we_o     (rd_we),
        .rd_waddr_o  (rd_waddr),
        .rd_data_o   (rd_data),
        .rf_ready_i  (rf_ready),
        .byp_raddr_i (byp_raddr),
        .byp_hit_o   (byp_hit),
        .byp_data_o  (byp_data),
        .count_o     (count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [4:0] a, input logic [31:0] d);
        if (ch == 0) begin
            ch_valid[0]    = v;
            ch_waddr[4:0]  = a;
            ch_data[31:0]  = d;
        end else begin
            ch_valid[1]    = v;
            ch_waddr[9:5]  = a;
            ch_data[63:32] = d;
        end
        #1;
    endtask

    task automatic set_byp(input logic [4:0] a);
        byp_raddr = a;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ch_valid  = '0;
        ch_waddr  = '0;
        ch_data   = '0;
        rf_ready  = 1'b0;
        byp_raddr = '0;
        #12;
        chk("reset_rd_we",    {63'd0, rd_we},    64'd0);
        chk("reset_count",    {61'd0, count},    64'd0);
        chk("reset_rd_waddr", {59'd0, rd_waddr}, 64'd0);
        chk("reset_rd_data",  {32'd0, rd_data},  64'd0);
        chk("reset_byp_hit",  {63'd0, byp_hit},  64'd0);
        chk("reset_byp_data", {32'd0, byp_data}, 64'd0);
        rst_n = 1'b1;
        step();

        // Single write x5 = DEADBEEF through ch0, drained immediately
        rf_ready = 1'b1;
        set_ch(0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("t1_ready", {62'd0, ch_ready}, 64'h1);
        step();
        set_ch(0, 1'b0, 5'd0, 32'h0);
        set_byp(5'd5);
        chk("t1_rd_we",    {63'd0, rd_we},    64'd1);
        chk("t1_rd_waddr", {59'd0, rd_waddr}, 64'd5);
        chk("t1_rd_data",  {32'd0, rd_data},  64'hDEADBEEF);
        chk("t1_count",    {61'd0, count},    64'd1);
        chk("t1_byp_hit",  {63'd0, byp_hit},  64'd1);
        chk("t1_byp_data", {32'd0, byp_data}, 64'hDEADBEEF);
        step();
        chk("t1_count_drained", {61'd0, count}, 64'd0);
        chk("t1_rd_we_low",     {63'd0, rd_we}, 64'd0);

        // Both channels requesting; last grant was ch0 so ch1 goes first
        set_ch(0, 1'b1, 5'd1, 32'h11);
        set_ch(1, 1'b1, 5'd2, 32'h22);
        chk("t2_ready_a", {62'd0, ch_ready}, 64'h2);
        step();
        chk("t2_ready_b",  {62'd0, ch_ready}, 64'h1);
        chk("t2_rd_a",     {59'd0, rd_waddr}, 64'd2);
        chk("t2_data_a",   {32'd0, rd_data},  64'h22);
        chk("t2_count_a",  {61'd0, count},    64'd1);
        step();
        chk("t2_ready_c",  {62'd0, ch_ready}, 64'h2);
        chk("t2_rd_b",     {59'd0, rd_waddr}, 64'd1);
        chk("t2_data_b",   {32'd0, rd_data},  64'h11);
        chk("t2_count_b",  {61'd0, count},    64'd1);
        step();
        set_ch(0, 1'b0, 5'd0, 32'h0);
        set_ch(1, 1'b0, 5'd0, 32'h0);
        chk("t2_rd_c",     {59'd0, rd_waddr}, 64'd2);
        chk("t2_data_c",   {32'd0, rd_data},  64'h22);
        chk("t2_count_c",  {61'd0, count},    64'd1);
        step();
        chk("t2_count_end", {61'd0, count}, 64'd0);

        // Fill the buffer with the register file stalled
        rf_ready = 1'b0;
        set_ch(0, 1'b1, 5'd3, 32'h1);
        chk("t3_ready_first", {62'd0, ch_ready}, 64'h1);
        step();
        chk("t3_count1", {61'd0, count}, 64'd1);
        set_ch(0, 1'b1, 5'd3, 32'h2);
        step();
        set_ch(0, 1'b1, 5'd7, 32'h77);
        step();
        set_ch(0, 1'b1, 5'd8, 32'h88);
        step();
        set_ch(0, 1'b1, 5'd9, 32'h99);
        chk("t3_count_full", {61'd0, count},    64'd4);
        chk("t3_ready_full", {62'd0, ch_ready}, 64'h0);
        chk("t3_head_addr",  {59'd0, rd_waddr}, 64'd3);
        chk("t3_head_data",  {32'd0, rd_data},  64'h1);

        // Bypass: youngest x3 wins, x0 never hits, absent register misses
        set_byp(5'd3);
        chk("byp_x3_hit",  {63'd0, byp_hit},  64'd1);
        chk("byp_x3_data", {32'd0, byp_data}, 64'h2);
        set_byp(5'd8);
        chk("byp_x8_data", {32'd0, byp_data}, 64'h88);
        set_byp(5'd0);
        chk("byp_x0_hit",  {63'd0, byp_hit},  64'd0);
        chk("byp_x0_data", {32'd0, byp_data}, 64'h0);
        set_byp(5'd4);
        chk("byp_miss_hit", {63'd0, byp_hit}, 64'd0);

        // x0 write on ch1 while full is accepted and discarded
        set_ch(0, 1'b0, 5'd0, 32'h0);
        set_ch(1, 1'b1, 5'd0, 32'h55);
        chk("x0_ready", {62'd0, ch_ready}, 64'h2);
        step();
        set_ch(1, 1'b0, 5'd0, 32'h0);
        chk("x0_count", {61'd0, count},    64'd4);
        chk("x0_head",  {59'd0, rd_waddr}, 64'd3);

        // Simultaneous push and pop while full
        rf_ready = 1'b1;
        set_ch(0, 1'b1, 5'd9, 32'h99);
        chk("pp_ready", {62'd0, ch_ready}, 64'h1);
        step();
        set_ch(0, 1'b0, 5'd0, 32'h0);
        chk("pp_count",     {61'd0, count},    64'd4);
        chk("pp_rd_we",     {63'd0, rd_we},    64'd1);
        chk("pp_head_addr", {59'd0, rd_waddr}, 64'd3);
        chk("pp_head_data", {32'd0, rd_data},  64'h2);
        set_byp(5'd3);
        chk("pp_byp_data",  {32'd0, byp_data}, 64'h2);
        step();
        rf_ready = 1'b0;
        #1;
        chk("pre_rst_count", {61'd0, count},    64'd3);
        chk("pre_rst_head",  {59'd0, rd_waddr}, 64'd7);

        // Asynchronous reset with three entries buffered
        set_byp(5'd7);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_we",   {63'd0, rd_we},    64'd0);
        chk("rst_count",   {61'd0, count},    64'd0);
        chk("rst_rd_addr", {59'd0, rd_waddr}, 64'd0);
        chk("rst_byp_hit", {63'd0, byp_hit},  64'd0);
        step();
        rst_n = 1'b1;
        set_ch(0, 1'b1, 5'd10, 32'hA0);
        set_ch(1, 1'b1, 5'd11, 32'hB0);
        chk("post_rst_ready", {62'd0, ch_ready}, 64'h1);
        step();
        set_ch(0, 1'b0, 5'd0, 32'h0);
        set_ch(1, 1'b0, 5'd0, 32'h0);
        chk("post_rst_count", {61'd0, count},    64'd1);
        chk("post_rst_addr",  {59'd0, rd_waddr}, 64'd10);
        chk("post_rst_data",  {32'd0, rd_data},  64'hA0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
